// File: rtl/nibble_unpacker.sv
// Serialises a packed word of narrow signed elements into one element per cycle,
// LSB element first, with valid/ready on both sides and no bubble between words.
module nibble_unpacker #(
  parameter int IN_SIZE   = 4,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WORD_SIZE-1:0] word_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  output logic [IN_SIZE-1:0]   elem_o,
  output logic                 elem_valid_o,
  input  logic                 elem_ready_i,
  output logic                 elem_last_o
);

  localparam int N_ELEMS = WORD_SIZE / IN_SIZE;
  localparam int IDX_W   = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

  if ((WORD_SIZE % IN_SIZE) != 0 || WORD_SIZE < 2 * IN_SIZE) begin : g_bad_geometry
    $error("nibble_unpacker: WORD_SIZE must be a multiple of IN_SIZE and >= 2*IN_SIZE");
  end

  typedef enum logic {IDLE, SERIAL} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] word_buf, word_buf_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic                 in_xfer, out_xfer;

  // Outputs depend only on registered state, except word_ready_o which lets a
  // new word land in the same cycle the last element leaves.
  assign elem_valid_o = (state == SERIAL);
  assign elem_last_o  = (state == SERIAL) && (idx == LAST_IDX);
  assign elem_o       = (state == SERIAL) ? word_buf[idx*IN_SIZE +: IN_SIZE] : '0;
  assign word_ready_o = (state == IDLE) || (elem_last_o && elem_ready_i);

  assign in_xfer  = word_valid_i && word_ready_o;
  assign out_xfer = elem_valid_o && elem_ready_i;

  always_comb begin
    state_nxt    = state;
    word_buf_nxt = word_buf;
    idx_nxt      = idx;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          word_buf_nxt = word_i;
          idx_nxt      = '0;
          state_nxt    = SERIAL;
        end
      end
      SERIAL: begin
        if (out_xfer) begin
          if (idx != LAST_IDX) begin
            idx_nxt = idx + 1'b1;
          end else if (in_xfer) begin
            word_buf_nxt = word_i;
            idx_nxt      = '0;
          end else begin
            idx_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      word_buf <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      word_buf <= word_buf_nxt;
      idx      <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_nibble_unpacker.sv
// Directed bench for nibble_unpacker: single word, back-to-back words,
// backpressure, stall on the last element, async reset mid-word, sign-extended view.
module tb_nibble_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  elem;
  logic        elem_valid;
  logic        elem_ready;
  logic        elem_last;

  int n_cmp = 0;
  int n_err = 0;

  nibble_unpacker #(.IN_SIZE(4), .WORD_SIZE(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .word_i      (word),
    .word_valid_i(word_valid),
    .word_ready_o(word_ready),
    .elem_o      (elem),
    .elem_valid_o(elem_valid),
    .elem_ready_i(elem_ready),
    .elem_last_o (elem_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sext(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

  logic [3:0] seq_a  [8]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
  logic [3:0] seq_b2b[16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                              4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [3:0] seq_c  [8]  = '{4'h0, 4'h8, 4'hF, 4'h7, 4'hF, 4'h8, 4'hF, 4'h0};
  logic [7:0] ext_c  [8]  = '{8'h00, 8'hF8, 8'hFF, 8'h07, 8'hFF, 8'hF8, 8'hFF, 8'h00};

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; word = '0; word_valid = 1'b0; elem_ready = 1'b0;
    #3;
    chk("rst_valid", elem_valid, 0);
    chk("rst_elem",  elem,       0);
    chk("rst_last",  elem_last,  0);
    tick(); tick();
    #2 rst = 1'b0;
    tick();
    chk("idle_ready", word_ready, 1);
    chk("idle_valid", elem_valid, 0);

    // single word
    word = 32'h87654321; word_valid = 1'b1; elem_ready = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("single_elem",  elem,       seq_a[i]);
      chk("single_valid", elem_valid, 1);
      chk("single_last",  elem_last,  (i == 7));
      chk("single_ready", word_ready, (i == 7));
      tick();
    end
    chk("single_idle_valid", elem_valid, 0);
    chk("single_idle_ready", word_ready, 1);

    // back-to-back words
    word = 32'h87654321; word_valid = 1'b1;
    tick();
    word = 32'hFEDCBA90;
    for (int k = 0; k < 16; k++) begin
      chk("b2b_elem",  elem,       seq_b2b[k]);
      chk("b2b_valid", elem_valid, 1);
      chk("b2b_last",  elem_last,  (k == 7 || k == 15));
      if (k < 7) chk("b2b_ready_low", word_ready, 0);
      if (k == 7) chk("b2b_ready_accept", word_ready, 1);
      tick();
      if (k == 7) word_valid = 1'b0;
    end
    chk("b2b_idle_valid", elem_valid, 0);

    // backpressure on element 0x3
    word = 32'h87654321; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick(); tick();
    elem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("bp_hold_elem",  elem,       4'h3);
      chk("bp_hold_valid", elem_valid, 1);
      tick();
    end
    elem_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      chk("bp_resume_elem", elem, seq_a[i]);
      tick();
    end
    chk("bp_idle_valid", elem_valid, 0);

    // stall on last element with a new word waiting
    word = 32'h87654321; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    elem_ready = 1'b0;
    word = 32'h0F8F7F80; word_valid = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("stall_elem",  elem,       4'h8);
      chk("stall_last",  elem_last,  1);
      chk("stall_ready", word_ready, 0);
      tick();
    end
    elem_ready = 1'b1;
    #1;
    chk("stall_release_ready", word_ready, 1);
    tick();
    word_valid = 1'b0;

    // new word, viewed raw and sign-extended to 8 bits
    for (int i = 0; i < 8; i++) begin
      chk("chain_elem", elem,       seq_c[i]);
      chk("chain_ext",  sext(elem), ext_c[i]);
      chk("chain_last", elem_last,  (i == 7));
      tick();
    end
    chk("chain_idle_valid", elem_valid, 0);

    // asynchronous reset mid-word, after element 0x3 is consumed
    word = 32'h87654321; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_elem", elem, 4'h4);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", elem_valid, 0);
    chk("arst_elem",  elem,       0);
    chk("arst_last",  elem_last,  0);
    tick(); tick();
    #2 rst = 1'b0;
    tick();
    chk("post_rst_ready", word_ready, 1);
    chk("post_rst_valid", elem_valid, 0);
    word = 32'h11111111; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_elem", elem,      4'h1);
      chk("post_rst_last", elem_last, (i == 7));
      tick();
    end
    chk("post_rst_idle", elem_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
